// File: rtl/lif_neuron_multi_system.sv
// N-channel leaky integrate-and-fire neuron with a serial, LSB-first parameter
// loader, programmable refractory period and saturating spike counter.
module lif_neuron_multi_system #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 3,
  parameter int W_W    = 3,
  parameter int V_W    = 8,
  parameter int LC_W   = 4,
  parameter int RF_W   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   input_enable,
  input  logic [NUM_CH*IN_W-1:0] chan_in,
  input  logic                   load_mode,
  input  logic                   serial_data,
  output logic                   spike_out,
  output logic [V_W-1:0]         v_mem_out,
  output logic                   params_ready,
  output logic                   refractory,
  output logic [7:0]             spike_count
);

  localparam int FL   = NUM_CH*W_W + 2*V_W + LC_W + RF_W;
  localparam int BC_W = $clog2(FL + 1);
  localparam int S_W  = IN_W + W_W + $clog2(NUM_CH);
  localparam int X_W  = V_W + S_W + 2;
  localparam int L_LO = NUM_CH*W_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INTEGRATE = 2'd1,
    ST_REFRACT   = 2'd2
  } state_t;

  logic [FL-2:0]          shreg_r;
  logic [BC_W-1:0]        bit_cnt_r;
  logic                   load_mode_d_r;
  logic                   params_ready_r;
  logic [NUM_CH*W_W-1:0]  weights_r;
  logic [V_W-1:0]         leak_rate_r;
  logic [V_W-1:0]         threshold_r;
  logic [LC_W-1:0]        leak_cycles_r;
  logic [RF_W-1:0]        refrac_cycles_r;
  state_t                 state_r;
  logic [V_W-1:0]         v_mem_r;
  logic [LC_W-1:0]        leak_ctr_r;
  logic [RF_W-1:0]        refrac_ctr_r;
  logic                   spike_r;
  logic                   refractory_r;
  logic [7:0]             spike_count_r;

  logic [FL-1:0]          frame_s;
  logic [BC_W-1:0]        cnt_base_s;
  logic [S_W-1:0]         sum_s;
  logic                   leak_s;
  logic [X_W-1:0]         leak_amt_s;
  logic [X_W-1:0]         v_wide_s;
  logic [V_W-1:0]         v_clip_s;
  logic                   spike_s;

  // Frame as it would look with this cycle's bit; a rising load_mode restarts at bit 0
  always_comb begin
    frame_s = {serial_data, shreg_r};
    if (load_mode && !load_mode_d_r) begin
      cnt_base_s = '0;
    end else begin
      cnt_base_s = bit_cnt_r;
    end
  end

  // Serial loader: shift bits in, commit the frame on its last bit
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_r         <= '0;
      bit_cnt_r       <= '0;
      load_mode_d_r   <= 1'b0;
      params_ready_r  <= 1'b0;
      weights_r       <= '0;
      leak_rate_r     <= '0;
      threshold_r     <= '0;
      leak_cycles_r   <= '0;
      refrac_cycles_r <= '0;
    end else if (enable) begin
      load_mode_d_r <= load_mode;
      if (load_mode) begin
        if (cnt_base_s < BC_W'(FL)) begin
          shreg_r        <= frame_s[FL-1:1];
          bit_cnt_r      <= cnt_base_s + BC_W'(1);
          params_ready_r <= (cnt_base_s == BC_W'(FL - 1));
          if (cnt_base_s == BC_W'(FL - 1)) begin
            weights_r       <= frame_s[L_LO-1:0];
            leak_rate_r     <= frame_s[L_LO +: V_W];
            threshold_r     <= frame_s[L_LO+V_W +: V_W];
            leak_cycles_r   <= frame_s[L_LO+2*V_W +: LC_W];
            refrac_cycles_r <= frame_s[L_LO+2*V_W+LC_W +: RF_W];
          end
        end
      end else begin
        bit_cnt_r <= '0;
      end
    end
  end

  // Weighted input sum, leak decision and clipped next membrane value
  always_comb begin
    sum_s = '0;
    if (input_enable) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sum_s = sum_s + S_W'(chan_in[i*IN_W +: IN_W]) * S_W'(weights_r[i*W_W +: W_W]);
      end
    end else begin
      sum_s = '0;
    end
    leak_s = (leak_ctr_r == leak_cycles_r);
    if (leak_s) begin
      leak_amt_s = X_W'(leak_rate_r);
    end else begin
      leak_amt_s = '0;
    end
    v_wide_s = X_W'(v_mem_r) + X_W'(sum_s) - leak_amt_s;
    if (v_wide_s[X_W-1]) begin
      v_clip_s = '0;
    end else if (|v_wide_s[X_W-2:V_W]) begin
      v_clip_s = '1;
    end else begin
      v_clip_s = v_wide_s[V_W-1:0];
    end
    spike_s = (v_clip_s >= threshold_r);
  end

  // Neuron state machine with registered spike, refractory and counter outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      v_mem_r       <= '0;
      leak_ctr_r    <= '0;
      refrac_ctr_r  <= '0;
      spike_r       <= 1'b0;
      refractory_r  <= 1'b0;
      spike_count_r <= '0;
    end else if (enable) begin
      if (load_mode || !params_ready_r) begin
        state_r      <= ST_IDLE;
        v_mem_r      <= '0;
        leak_ctr_r   <= '0;
        refrac_ctr_r <= '0;
        spike_r      <= 1'b0;
        refractory_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r      <= ST_INTEGRATE;
            spike_r      <= 1'b0;
            refractory_r <= 1'b0;
          end
          ST_INTEGRATE: begin
            if (spike_s) begin
              spike_r    <= 1'b1;
              v_mem_r    <= '0;
              leak_ctr_r <= '0;
              if (spike_count_r != 8'hFF) begin
                spike_count_r <= spike_count_r + 8'd1;
              end
              if (refrac_cycles_r != RF_W'(0)) begin
                state_r      <= ST_REFRACT;
                refrac_ctr_r <= refrac_cycles_r;
                refractory_r <= 1'b1;
              end
            end else begin
              spike_r    <= 1'b0;
              v_mem_r    <= v_clip_s;
              leak_ctr_r <= leak_s ? LC_W'(0) : leak_ctr_r + LC_W'(1);
            end
          end
          ST_REFRACT: begin
            spike_r <= 1'b0;
            v_mem_r <= '0;
            if (refrac_ctr_r < RF_W'(2)) begin
              state_r      <= ST_INTEGRATE;
              refrac_ctr_r <= '0;
              refractory_r <= 1'b0;
            end else begin
              refrac_ctr_r <= refrac_ctr_r - RF_W'(1);
            end
          end
          default: begin
            state_r      <= ST_IDLE;
            v_mem_r      <= '0;
            spike_r      <= 1'b0;
            refractory_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spike_out    = spike_r;
  assign v_mem_out    = v_mem_r;
  assign params_ready = params_ready_r;
  assign refractory   = refractory_r;
  assign spike_count  = spike_count_r;

endmodule

// File: tb/tb_lif_neuron_multi_system.sv
// Bench for lif_neuron_multi_system: directed table, corner sequences and
// randomized traffic checked every cycle against a behavioural model.
module tb_lif_neuron_multi_system;

  localparam int FL = 35;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        input_enable = 1'b0;
  logic [11:0] chan_in = '0;
  logic        load_mode = 1'b0;
  logic        serial_data = 1'b0;
  logic        spike_out;
  logic [7:0]  v_mem_out;
  logic        params_ready;
  logic        refractory;
  logic [7:0]  spike_count;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  bit m_bits[$];
  bit m_lm_prev, m_ready, m_active, m_spike;
  int m_v, m_lc, m_refrac_left, m_count;
  int p_w[4];
  int p_l, p_t, p_lc, p_rf;

  typedef struct {
    logic        ie;
    logic [11:0] chan;
    int          exp_v;
    logic        exp_spike;
    logic        exp_refr;
  } vec_t;
  vec_t vecs[13];

  lif_neuron_multi_system dut (
    .clk(clk), .reset(reset), .enable(enable), .input_enable(input_enable),
    .chan_in(chan_in), .load_mode(load_mode), .serial_data(serial_data),
    .spike_out(spike_out), .v_mem_out(v_mem_out), .params_ready(params_ready),
    .refractory(refractory), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int fld(input int lo, input int w);
    int r = 0;
    for (int k = 0; k < w; k++) if (m_bits[lo + k]) r += (1 << k);
    return r;
  endfunction

  function automatic logic [FL-1:0] mk_frame(input int w0, input int w1, input int w2,
      input int w3, input int l, input int t, input int lc, input int rf);
    return {rf[2:0], lc[3:0], t[7:0], l[7:0], w3[2:0], w2[2:0], w1[2:0], w0[2:0]};
  endfunction

  // One clock of the neuron as described by its rules
  function automatic void model_step();
    bit ready_old, leak;
    int sum, vn;
    if (reset) begin
      m_bits.delete();
      m_lm_prev = 0; m_ready = 0; m_active = 0; m_spike = 0;
      m_v = 0; m_lc = 0; m_refrac_left = 0; m_count = 0;
      for (int i = 0; i < 4; i++) p_w[i] = 0;
      p_l = 0; p_t = 0; p_lc = 0; p_rf = 0;
      return;
    end
    if (!enable) return;
    ready_old = m_ready;
    if (load_mode || !ready_old) begin
      m_active = 0; m_v = 0; m_lc = 0; m_refrac_left = 0; m_spike = 0;
    end else if (!m_active) begin
      m_active = 1; m_spike = 0;
    end else if (m_refrac_left > 0) begin
      m_refrac_left--; m_spike = 0; m_v = 0;
    end else begin
      sum = 0;
      if (input_enable) for (int i = 0; i < 4; i++) sum += int'(chan_in[i*3 +: 3]) * p_w[i];
      leak = (m_lc == p_lc);
      vn = m_v + sum - (leak ? p_l : 0);
      if (vn < 0) vn = 0;
      if (vn > 255) vn = 255;
      if (vn >= p_t) begin
        m_spike = 1; m_v = 0; m_lc = 0; m_refrac_left = p_rf;
        if (m_count < 255) m_count++;
      end else begin
        m_spike = 0; m_v = vn; m_lc = leak ? 0 : m_lc + 1;
      end
    end
    if (load_mode) begin
      if (!m_lm_prev) begin
        m_bits.delete();
        m_ready = 0;
      end
      if (m_bits.size() < FL) begin
        m_bits.push_back(serial_data);
        if (m_bits.size() == FL) begin
          for (int i = 0; i < 4; i++) p_w[i] = fld(i*3, 3);
          p_l = fld(12, 8); p_t = fld(20, 8); p_lc = fld(28, 4); p_rf = fld(32, 3);
          m_ready = 1;
        end
      end
    end else begin
      m_bits.delete();
    end
    m_lm_prev = load_mode;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("spike_out", spike_out, m_spike);
    check("v_mem_out", v_mem_out, m_v);
    check("params_ready", params_ready, m_ready);
    check("refractory", refractory, m_refrac_left > 0);
    check("spike_count", spike_count, m_count);
  endtask

  task automatic load_frame(input logic [FL-1:0] f, input int nbits);
    reset = 1'b0; enable = 1'b1; load_mode = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      serial_data = f[i];
      tick();
    end
    load_mode = 1'b0; serial_data = 1'b0;
  endtask

  initial begin
    logic [FL-1:0] frame_v;
    int bit_idx, bits_left;

    vecs[0]  = '{1'b1, {3'd1, 3'd1, 3'd1, 3'd1}, 0,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, {3'd1, 3'd1, 3'd1, 3'd1}, 4,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, {3'd1, 3'd1, 3'd1, 3'd1}, 8,  1'b0, 1'b0};
    vecs[3]  = '{1'b1, {3'd1, 3'd1, 3'd1, 3'd1}, 12, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, {3'd1, 3'd1, 3'd1, 3'd1}, 16, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, {3'd1, 3'd1, 3'd1, 3'd1}, 0,  1'b1, 1'b1};
    vecs[6]  = '{1'b1, {3'd1, 3'd1, 3'd1, 3'd1}, 0,  1'b0, 1'b1};
    vecs[7]  = '{1'b1, {3'd1, 3'd1, 3'd1, 3'd1}, 0,  1'b0, 1'b0};
    vecs[8]  = '{1'b1, {3'd1, 3'd1, 3'd1, 3'd1}, 4,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, {3'd1, 3'd1, 3'd1, 3'd1}, 8,  1'b0, 1'b0};
    vecs[10] = '{1'b0, {3'd1, 3'd1, 3'd1, 3'd1}, 8,  1'b0, 1'b0};
    vecs[11] = '{1'b1, {3'd0, 3'd0, 3'd0, 3'd7}, 15, 1'b0, 1'b0};
    vecs[12] = '{1'b1, {3'd0, 3'd0, 3'd0, 3'd7}, 0,  1'b1, 1'b1};

    // reset state
    tick(); tick();
    check("reset_v", v_mem_out, 0);
    check("reset_ready", params_ready, 0);
    check("reset_count", spike_count, 0);

    // partial frame leaves the neuron unconfigured
    load_frame(mk_frame(1, 1, 1, 1, 0, 20, 0, 0), 20);
    input_enable = 1'b1; chan_in = {3'd1, 3'd1, 3'd1, 3'd1};
    for (int i = 0; i < 5; i++) tick();
    check("partial_ready", params_ready, 0);
    check("partial_v", v_mem_out, 0);
    check("partial_spike", spike_out, 0);

    // integrate, spike and refractory period from the table
    load_frame(mk_frame(1, 1, 1, 1, 0, 20, 0, 2), FL);
    for (int i = 0; i < 13; i++) begin
      input_enable = vecs[i].ie; chan_in = vecs[i].chan;
      tick();
      check($sformatf("vec%0d_v", i), v_mem_out, vecs[i].exp_v);
      check($sformatf("vec%0d_spike", i), spike_out, vecs[i].exp_spike);
      check($sformatf("vec%0d_refr", i), refractory, vecs[i].exp_refr);
    end
    check("table_count", spike_count, 2);

    // upper clip: 196 + 196 saturates at 255 and spikes at T=255
    load_frame(mk_frame(7, 7, 7, 7, 0, 255, 0, 0), FL);
    input_enable = 1'b1; chan_in = {3'd7, 3'd7, 3'd7, 3'd7};
    tick(); tick();
    check("clip_v196", v_mem_out, 196);
    tick();
    check("clip_spike", spike_out, 1);
    check("clip_v0", v_mem_out, 0);

    // leak every third cycle, floor at zero
    load_frame(mk_frame(1, 1, 1, 1, 3, 200, 2, 0), FL);
    chan_in = {3'd1, 3'd1, 3'd1, 3'd1};
    tick(); tick(); tick(); tick();
    check("leak_cycle3", v_mem_out, 9);
    input_enable = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("leak_floor", v_mem_out, 0);

    // threshold 0: spikes every cycle, counter saturates
    load_frame(mk_frame(0, 0, 0, 0, 0, 0, 0, 0), FL);
    for (int i = 0; i < 300; i++) tick();
    check("count_sat", spike_count, 255);
    check("sat_spike", spike_out, 1);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    enable = 1'b1;

    // reset during refractory period
    load_frame(mk_frame(7, 7, 7, 7, 0, 10, 0, 7), FL);
    input_enable = 1'b1; chan_in = {3'd7, 3'd7, 3'd7, 3'd7};
    tick(); tick(); tick();
    check("refr_before_reset", refractory, 1);
    reset = 1'b1;
    tick();
    check("rst_refr", refractory, 0);
    check("rst_spike", spike_out, 0);
    check("rst_count", spike_count, 0);
    check("rst_ready", params_ready, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("post_rst_ready", params_ready, 0);
    check("post_rst_v", v_mem_out, 0);

    // reset in the middle of a load
    load_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      serial_data = 1'($urandom);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; load_mode = 1'b0;
    tick();
    check("midload_ready", params_ready, 0);

    // randomized traffic against the model
    bit_idx = 0; bits_left = FL;
    frame_v = mk_frame(2, 1, 3, 1, 4, 60, 3, 2);
    for (int c = 0; c < 3000; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 599) == 0);
      if (bits_left == 0 && $urandom_range(0, 149) == 0) begin
        frame_v = mk_frame($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                           $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 150),
                           $urandom_range(0, 15), $urandom_range(0, 7));
        bit_idx = 0;
        bits_left = ($urandom_range(0, 7) == 0) ? $urandom_range(1, FL - 1) : FL;
      end
      if (bits_left > 0) begin
        load_mode = 1'b1;
        serial_data = frame_v[bit_idx];
        if (enable && !reset) begin
          bit_idx++; bits_left--;
        end
      end else begin
        load_mode = 1'b0;
        serial_data = 1'($urandom);
        input_enable = ($urandom_range(0, 3) != 0);
        chan_in = 12'($urandom);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
